// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, forwarding selects and the control bundle shared
// by the ID/EX stage and its forwarding muxes.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_ADDU = 4'b1010,
        ALU_NOR  = 4'b1100,
        ALU_SUBU = 4'b1110,
        ALU_SLL  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    // EX/MEM is younger than MEM/WB, so it wins; r0 is never forwarded
    function automatic fwd_sel_e fwd_pick(
        input logic [4:0] addr,
        input logic       exm_we,
        input logic [4:0] exm_rd,
        input logic       mwb_we,
        input logic [4:0] mwb_rd
    );
        if (exm_we && exm_rd != 5'd0 && exm_rd == addr)
            return FWD_EXM;
        if (mwb_we && mwb_rd != 5'd0 && mwb_rd == addr)
            return FWD_MWB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs, forwarding sources and ALU-side
// outputs of the ID/EX stage, bundled with master/slave modports.
interface id_ex_stage_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic             valid_in;
    logic [W-1:0]     rs_data;
    logic [W-1:0]     rt_data;
    logic [W-1:0]     imm;
    logic [4:0]       shamt_in;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [4:0]       rd_addr;
    logic [3:0]       alu_ctrl_in;
    logic             alu_src;
    logic             reg_write_in;
    logic             mem_read_in;
    logic             mem_write_in;
    logic             mem_to_reg_in;
    logic             exm_reg_write;
    logic [4:0]       exm_rd;
    logic [W-1:0]     exm_result;
    logic             mwb_reg_write;
    logic [4:0]       mwb_rd;
    logic [W-1:0]     mwb_result;

    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [4:0]       shamt;
    logic [3:0]       ALUout;
    logic [W-1:0]     store_data;
    logic [4:0]       rd_out;
    logic             reg_write_out;
    logic             mem_read_out;
    logic             mem_write_out;
    logic             mem_to_reg_out;
    logic             valid_out;
    logic             load_use;
    logic [CNT_W-1:0] bubble_cnt;

    modport slave (
        input  stall, flush, valid_in,
        input  rs_data, rt_data, imm, shamt_in,
        input  rs_addr, rt_addr, rd_addr,
        input  alu_ctrl_in, alu_src,
        input  reg_write_in, mem_read_in,
        input  mem_write_in, mem_to_reg_in,
        input  exm_reg_write, exm_rd, exm_result,
        input  mwb_reg_write, mwb_rd, mwb_result,
        output x, y, shamt, ALUout, store_data,
        output rd_out, reg_write_out, mem_read_out,
        output mem_write_out, mem_to_reg_out,
        output valid_out, load_use, bubble_cnt
    );

    modport master (
        output stall, flush, valid_in,
        output rs_data, rt_data, imm, shamt_in,
        output rs_addr, rt_addr, rd_addr,
        output alu_ctrl_in, alu_src,
        output reg_write_in, mem_read_in,
        output mem_write_in, mem_to_reg_in,
        output exm_reg_write, exm_rd, exm_result,
        output mwb_reg_write, mwb_rd, mwb_result,
        input  x, y, shamt, ALUout, store_data,
        input  rd_out, reg_write_out, mem_read_out,
        input  mem_write_out, mem_to_reg_out,
        input  valid_out, load_use, bubble_cnt
    );
endinterface

// File: rtl/fwd_mux.sv
// fwd_mux: picks one ALU operand from the register copy or the EX/MEM
// and MEM/WB results; EN=0 always passes the register copy.
module fwd_mux import alu_pkg::*; #(
    parameter int W  = 32,
    parameter bit EN = 1'b1
) (
    input  logic [4:0]   addr,
    input  logic [W-1:0] reg_data,
    input  logic         exm_we,
    input  logic [4:0]   exm_rd,
    input  logic [W-1:0] exm_result,
    input  logic         mwb_we,
    input  logic [4:0]   mwb_rd,
    input  logic [W-1:0] mwb_result,
    output logic [W-1:0] data
);
    fwd_sel_e sel;

    always_comb begin
        sel = FWD_REG;
        if (EN)
            sel = fwd_pick(addr, exm_we, exm_rd, mwb_we, mwb_rd);
        unique case (sel)
            FWD_EXM: data = exm_result;
            FWD_MWB: data = mwb_result;
            default: data = reg_data;
        endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with load-use bubbles and operand forwarding.
// ID_EX_FWD_EN enables forwarding; without it load_use covers all writers.
module id_ex_stage import alu_pkg::*; #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
`ifdef ID_EX_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic         valid;
        ctrl_t        ctrl;
        logic         alu_src;
        logic [3:0]   alu_ctrl;
        logic [4:0]   shamt;
        logic [4:0]   rs_addr;
        logic [4:0]   rt_addr;
        logic [4:0]   rd;
        logic [W-1:0] imm;
        logic [W-1:0] rs_data;
        logic [W-1:0] rt_data;
    } ent_t;

    ent_t             ent_q;
    ent_t             ent_d;
    ent_t             ent_in;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic             load_use;
    logic [W-1:0]     fwd_rs;
    logic [W-1:0]     fwd_rt;

    function automatic logic hit(
        input logic       we,
        input logic [4:0] rd,
        input logic [4:0] a,
        input logic [4:0] b
    );
        return we && rd != 5'd0 && (rd == a || rd == b);
    endfunction

    always_comb begin
        load_use = 1'b0;
`ifdef ID_EX_FWD_EN
        load_use = bus.valid_in &
            hit(ent_q.valid & ent_q.ctrl.mem_read,
                ent_q.rd, bus.rs_addr, bus.rt_addr);
`else
        // no bypass: any pending writer of a source must drain first
        load_use = bus.valid_in & (
            hit(ent_q.valid &
                (ent_q.ctrl.reg_write | ent_q.ctrl.mem_read),
                ent_q.rd, bus.rs_addr, bus.rt_addr) |
            hit(bus.exm_reg_write, bus.exm_rd,
                bus.rs_addr, bus.rt_addr) |
            hit(bus.mwb_reg_write, bus.mwb_rd,
                bus.rs_addr, bus.rt_addr));
`endif
    end

    always_comb begin
        ent_in                = '0;
        ent_in.valid          = bus.valid_in;
        ent_in.ctrl.reg_write = bus.reg_write_in;
        ent_in.ctrl.mem_read  = bus.mem_read_in;
        ent_in.ctrl.mem_write = bus.mem_write_in;
        ent_in.ctrl.mem_to_reg = bus.mem_to_reg_in;
        ent_in.alu_src        = bus.alu_src;
        ent_in.alu_ctrl       = bus.alu_ctrl_in;
        ent_in.shamt          = bus.shamt_in;
        ent_in.rs_addr        = bus.rs_addr;
        ent_in.rt_addr        = bus.rt_addr;
        ent_in.rd             = bus.rd_addr;
        ent_in.imm            = bus.imm;
        ent_in.rs_data        = bus.rs_data;
        ent_in.rt_data        = bus.rt_data;
    end

    always_comb begin
        ent_d        = ent_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush) begin
            ent_d = '0;
        end else if (bus.stall) begin
            ent_d = ent_q;
        end else if (load_use) begin
            ent_d = '0;
            if (bubble_cnt_q != '1)
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else begin
            ent_d = ent_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q        <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ent_q        <= ent_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    fwd_mux #(.W(W), .EN(FWD_EN)) u_fwd_rs (
        .addr       (ent_q.rs_addr),
        .reg_data   (ent_q.rs_data),
        .exm_we     (bus.exm_reg_write),
        .exm_rd     (bus.exm_rd),
        .exm_result (bus.exm_result),
        .mwb_we     (bus.mwb_reg_write),
        .mwb_rd     (bus.mwb_rd),
        .mwb_result (bus.mwb_result),
        .data       (fwd_rs)
    );

    fwd_mux #(.W(W), .EN(FWD_EN)) u_fwd_rt (
        .addr       (ent_q.rt_addr),
        .reg_data   (ent_q.rt_data),
        .exm_we     (bus.exm_reg_write),
        .exm_rd     (bus.exm_rd),
        .exm_result (bus.exm_result),
        .mwb_we     (bus.mwb_reg_write),
        .mwb_rd     (bus.mwb_rd),
        .mwb_result (bus.mwb_result),
        .data       (fwd_rt)
    );

    assign bus.x              = fwd_rs;
    assign bus.y              = ent_q.alu_src ? ent_q.imm : fwd_rt;
    assign bus.store_data     = fwd_rt;
    assign bus.shamt          = ent_q.shamt;
    assign bus.ALUout         = ent_q.alu_ctrl;
    assign bus.rd_out         = ent_q.rd;
    assign bus.reg_write_out  = ent_q.ctrl.reg_write;
    assign bus.mem_read_out   = ent_q.ctrl.mem_read;
    assign bus.mem_write_out  = ent_q.ctrl.mem_write;
    assign bus.mem_to_reg_out = ent_q.ctrl.mem_to_reg;
    assign bus.valid_out      = ent_q.valid;
    assign bus.load_use       = load_use;
    assign bus.bubble_cnt     = bubble_cnt_q;
endmodule
